retire_trace_tx: RTL and testbench

- Hardware producer of the per-instruction retirement trace for the pipelined CPU. It sits beside the writeback stage.
- Captures one retirement event per cycle: register write, memory write, plain retire or halt.
- Buffers events in a small FIFO and serialises each one as a 2-4 word record over a 16-bit valid/ready stream to an off-chip or bench trace sink.
- Tracks the instruction count (INUM) and the cycle count, so a sink can rebuild the same trace the simulation log produces.

---
 rtl/retire_trace_tx.sv | 217 +++++++++++++++++++++
 tb/tb_retire_trace_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_tx.sv
// Retirement trace producer: captures one retire event per cycle into a small FIFO
// and serialises each as a 2-4 word record on a 16-bit valid/ready stream.
module retire_trace_tx #(
  parameter int DEPTH   = 8,
  parameter int CYCLE_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ret_valid,
  input  logic [15:0] ret_pc,
  input  logic        ret_regwrite,
  input  logic [3:0]  ret_reg,
  input  logic [15:0] ret_wdata,
  input  logic        ret_memwrite,
  input  logic [15:0] ret_addr,
  input  logic [15:0] ret_mdata,
  input  logic        ret_halt,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        overflow,
  output logic [15:0] inst_count,
  output logic        done,
  output logic [2:0]  dbg_state
);

  // Stream contract: a word moves only when tx_valid && tx_ready on a rising edge;
  // while tx_valid=1 and tx_ready=0 the word is held, and tx_valid only falls
  // after a handshake (or on reset).

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PC   = 3'd2;
  localparam logic [2:0] S_W2   = 3'd3;
  localparam logic [2:0] S_W3   = 3'd4;

  localparam logic [1:0] T_PLAIN = 2'd0;
  localparam logic [1:0] T_REG   = 2'd1;
  localparam logic [1:0] T_MEM   = 2'd2;
  localparam logic [1:0] T_HALT  = 2'd3;

  typedef struct packed {
    logic [1:0]  typ;
    logic [3:0]  rg;
    logic [9:0]  inum;
    logic [15:0] pc;
    logic [15:0] w2;
    logic [15:0] w3;
  } entry_t;

  entry_t             fifo_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [CYCLE_W-1:0] cycle_q;
  logic [15:0]        inst_count_q;
  logic               done_latched_q, done_q, done_d, overflow_q;
  logic [2:0]         state_q, state_d;
  logic               tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic [15:0]        tx_data_q, tx_data_d;

  logic   capture, push, pop, hs;
  entry_t new_e, head, next_head;

  assign capture = ret_valid && !done_latched_q;
  // Fullness uses the registered count, so a same-cycle pop never rescues a push.
  assign push    = capture && (count_q != FULL);
  assign hs      = tx_valid_q && tx_ready;
  assign head      = fifo_q[rd_ptr_q];
  assign next_head = fifo_q[PW'(rd_ptr_q + 1'b1)];

  always_comb begin
    new_e      = '0;
    new_e.inum = inst_count_q[9:0];
    new_e.pc   = ret_pc;
    if (ret_halt) begin
      new_e.typ = T_HALT;
      new_e.w2  = cycle_q[15:0];
      new_e.w3  = inst_count_q + 16'd1;
    end else if (ret_regwrite) begin
      new_e.typ = T_REG;
      new_e.rg  = ret_reg;
      new_e.w2  = ret_wdata;
    end else if (ret_memwrite) begin
      new_e.typ = T_MEM;
      new_e.w2  = ret_addr;
      new_e.w3  = ret_mdata;
    end else begin
      new_e.typ = T_PLAIN;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    done_d     = done_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d    = S_HDR;
          tx_valid_d = 1'b1;
          tx_data_d  = {head.typ, head.rg, head.inum};
          tx_last_d  = 1'b0;
        end
      end
      S_HDR: begin
        if (hs) begin
          state_d   = S_PC;
          tx_data_d = head.pc;
          tx_last_d = (head.typ == T_PLAIN);
        end
      end
      S_PC: begin
        if (hs) begin
          if (head.typ == T_PLAIN) begin
            pop = 1'b1;
          end else begin
            state_d   = S_W2;
            tx_data_d = head.w2;
            tx_last_d = (head.typ == T_REG);
          end
        end
      end
      S_W2: begin
        if (hs) begin
          if (head.typ == T_REG) begin
            pop = 1'b1;
          end else begin
            state_d   = S_W3;
            tx_data_d = head.w3;
            tx_last_d = 1'b1;
          end
        end
      end
      S_W3: begin
        if (hs) begin
          pop = 1'b1;
          if (head.typ == T_HALT) done_d = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
        tx_last_d  = 1'b0;
      end
    endcase
    // A record finishing with another entry queued chains straight into its header.
    if (pop) begin
      if (count_q > CW'(1)) begin
        state_d    = S_HDR;
        tx_valid_d = 1'b1;
        tx_data_d  = {next_head.typ, next_head.rg, next_head.inum};
        tx_last_d  = 1'b0;
      end else begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
        tx_last_d  = 1'b0;
      end
    end
  end

  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_e;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      cycle_q        <= '0;
      inst_count_q   <= '0;
      done_latched_q <= 1'b0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
      state_q        <= S_IDLE;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= '0;
      tx_last_q      <= 1'b0;
    end else begin
      cycle_q    <= cycle_q + 1'b1;
      count_q    <= count_d;
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
      done_q     <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (capture) begin
        inst_count_q <= inst_count_q + 16'd1;
        if (!push) overflow_q <= 1'b1;
        if (ret_halt) done_latched_q <= 1'b1;
      end
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign tx_last    = tx_last_q;
  assign overflow   = overflow_q;
  assign inst_count = inst_count_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Bench for retire_trace_tx: directed scenarios plus random traffic, checked
// against a record-level model of the trace stream.
module tb_retire_trace_tx;

  localparam int DEPTH = 8;

  logic        clk, rst_n;
  logic        ret_valid, ret_regwrite, ret_memwrite, ret_halt;
  logic [15:0] ret_pc, ret_wdata, ret_addr, ret_mdata;
  logic [3:0]  ret_reg;
  logic        tx_valid, tx_last, tx_ready, overflow, done;
  logic [15:0] tx_data, inst_count;
  logic [2:0]  dbg_state;

  retire_trace_tx #(.DEPTH(DEPTH), .CYCLE_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_regwrite(ret_regwrite),
    .ret_reg(ret_reg), .ret_wdata(ret_wdata), .ret_memwrite(ret_memwrite),
    .ret_addr(ret_addr), .ret_mdata(ret_mdata), .ret_halt(ret_halt),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .overflow(overflow), .inst_count(inst_count), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected words {last,data}, record types in flight, observed words
  logic [16:0] exp_q[$];
  logic [1:0]  type_q[$];
  logic [16:0] got_q[$];
  int          rec_cnt;
  logic [15:0] m_inst;
  logic [31:0] m_cyc;
  logic        m_done_l, m_done, m_ovf;
  int          gap;
  int          checks, errors;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr_ev();
    ret_valid = 0; ret_regwrite = 0; ret_memwrite = 0; ret_halt = 0;
    ret_pc = '0; ret_reg = '0; ret_wdata = '0; ret_addr = '0; ret_mdata = '0;
  endtask

  task automatic set_ev(input logic h, input logic rw, input logic mw, input logic [15:0] pc,
                        input logic [3:0] rg, input logic [15:0] wd,
                        input logic [15:0] ad, input logic [15:0] md);
    ret_valid = 1; ret_halt = h; ret_regwrite = rw; ret_memwrite = mw;
    ret_pc = pc; ret_reg = rg; ret_wdata = wd; ret_addr = ad; ret_mdata = md;
  endtask

  // Advance one clock: update the model for the coming edge, then check outputs.
  task automatic step();
    logic [16:0] w;
    logic [1:0]  t, ct;
    logic [15:0] h;
    bit full, hs, stalled, mustv;
    full    = (rec_cnt == DEPTH);
    hs      = tx_valid && tx_ready;
    stalled = tx_valid && !tx_ready;
    mustv   = 0;
    if (!rst_n) begin
      exp_q.delete(); type_q.delete();
      rec_cnt = 0; m_inst = 0; m_cyc = 0; m_done_l = 0; m_done = 0; m_ovf = 0; gap = 0;
    end else begin
      if (hs) begin
        got_q.push_back({tx_last, tx_data});
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          if (w[16]) begin
            t = type_q.pop_front();
            mustv = (rec_cnt > 1);
            rec_cnt--;
            if (t == 2'd3) m_done = 1;
          end
        end
      end
      if (ret_valid && !m_done_l) begin
        ct = ret_halt ? 2'd3 : ret_regwrite ? 2'd1 : ret_memwrite ? 2'd2 : 2'd0;
        if (full) m_ovf = 1;
        else begin
          h = {ct, (ct == 2'd1) ? ret_reg : 4'd0, m_inst[9:0]};
          exp_q.push_back({1'b0, h});
          exp_q.push_back({(ct == 2'd0), ret_pc});
          if (ct == 2'd1) exp_q.push_back({1'b1, ret_wdata});
          if (ct == 2'd2) begin exp_q.push_back({1'b0, ret_addr}); exp_q.push_back({1'b1, ret_mdata}); end
          if (ct == 2'd3) begin exp_q.push_back({1'b0, m_cyc[15:0]}); exp_q.push_back({1'b1, m_inst + 16'd1}); end
          type_q.push_back(ct);
          rec_cnt++;
        end
        if (ct == 2'd3) m_done_l = 1;
        m_inst++;
      end
      m_cyc++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("inst_count", 32'(inst_count), 32'(m_inst));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("done", 32'(done), 32'(m_done));
    if (!rst_n) begin
      chk("rst_valid", 32'(tx_valid), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_last", 32'(tx_last), 0);
      chk("rst_state", 32'(dbg_state), 0);
    end else begin
      if (stalled) chk("hold_valid", 32'(tx_valid), 1);
      if (mustv) chk("b2b_valid", 32'(tx_valid), 1);
      if (tx_valid) begin
        gap = 0;
        if (exp_q.size() == 0) chk("spurious_valid", 32'(tx_valid), 0);
        else begin
          chk("data", 32'(tx_data), 32'(exp_q[0][15:0]));
          chk("last", 32'(tx_last), 32'(exp_q[0][16]));
        end
      end else if (exp_q.size() > 0) begin
        gap++;
        chk("latency_le1", 32'(gap <= 1), 1);
      end
    end
  endtask

  task automatic do_reset();
    clr_ev();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic idle(input int n);
    clr_ev();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int i;
    clr_ev();
    tx_ready = 1;
    i = 0;
    while (exp_q.size() > 0 && i < 300) begin step(); i++; end
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic cmp_got(input string tag, input logic [16:0] want[$]);
    chk(tag, 32'(got_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(want[i]));
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    tx_ready = 1;
    do_reset();

    // reg event: header, pc, wdata; latency one cycle after the push
    got_q.delete();
    set_ev(0, 1, 0, 16'h0004, 4'd3, 16'h1234, 16'h0, 16'h0);
    step();
    clr_ev();
    chk("t1_lat0", 32'(tx_valid), 0);
    step();
    chk("t1_lat1", 32'(tx_valid), 1);
    idle(6);
    cmp_got("t1_words", '{17'h04C00, 17'h00004, 17'h11234});
    chk("t1_inst", 32'(inst_count), 1);

    // mem record as INUM 5 followed back-to-back by a plain record
    do_reset();
    for (int i = 0; i < 5; i++) begin set_ev(0, 0, 0, 16'(i), 4'd0, 16'h0, 16'h0, 16'h0); step(); end
    drain();
    got_q.delete();
    set_ev(0, 0, 1, 16'h0010, 4'd0, 16'h0, 16'h0040, 16'hBEEF); step();
    set_ev(0, 0, 0, 16'h0014, 4'd0, 16'h0, 16'h0, 16'h0); step();
    idle(10);
    cmp_got("t2_words", '{17'h08005, 17'h00010, 17'h00040, 17'h1BEEF, 17'h00006, 17'h10014});

    // overflow under backpressure, then ordered release
    do_reset();
    tx_ready = 0;
    for (int i = 0; i < 10; i++) begin
      set_ev(0, 1, 1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom));
      step();
    end
    idle(3);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_inst", 32'(inst_count), 10);
    got_q.delete();
    drain();
    chk("t3_len", 32'(got_q.size()), 24);
    for (int i = 0; i < 8 && 3 * i < got_q.size(); i++) chk("t3_inum", 32'(got_q[3 * i][9:0]), 32'(i));

    // halt at cycle 0x0123 after six events
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_ev(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom),
             16'($urandom), 16'($urandom), 16'($urandom));
      step();
    end
    drain();
    n = 0;
    while (m_cyc[15:0] != 16'h0123 && n < 400) begin step(); n++; end
    chk("t4_reach_cycle", 32'(m_cyc[15:0]), 32'h0123);
    got_q.delete();
    set_ev(1, 0, 0, 16'h0100, 4'd0, 16'h0, 16'h0, 16'h0);
    step();
    clr_ev();
    n = 0;
    while (!done && n < 20) begin step(); n++; end
    cmp_got("t4_words", '{17'h0C006, 17'h00100, 17'h00123, 17'h10007});
    for (int i = 0; i < 3; i++) begin set_ev(0, 1, 0, 16'h0200, 4'd1, 16'h1, 16'h0, 16'h0); step(); end
    idle(2);
    chk("t4_inst", 32'(inst_count), 7);
    chk("t4_done", 32'(done), 1);

    // reset in the middle of a mem record
    do_reset();
    set_ev(0, 0, 1, 16'h0050, 4'd0, 16'h0, 16'h0060, 16'h0070);
    got_q.delete();
    step();
    clr_ev();
    n = 0;
    while (got_q.size() < 2 && n < 20) begin step(); n++; end
    chk("t5_w1_seen", 32'(got_q.size()), 2);
    rst_n = 0;
    step();
    rst_n = 1;
    got_q.delete();
    set_ev(0, 0, 0, 16'h0022, 4'd0, 16'h0, 16'h0, 16'h0);
    step();
    idle(4);
    cmp_got("t5_words", '{17'h00000, 17'h10022});

    // regwrite and memwrite together emit a reg record
    do_reset();
    got_q.delete();
    set_ev(0, 1, 1, 16'h0030, 4'd5, 16'hAAAA, 16'h5555, 16'h7777);
    step();
    idle(5);
    cmp_got("t6_words", '{17'h05400, 17'h00030, 17'h1AAAA});

    // random traffic with random backpressure
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1)
        set_ev(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
               4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      else clr_ev();
      tx_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    drain();
    set_ev(1, 0, 0, 16'hFFFE, 4'd0, 16'h0, 16'h0, 16'h0);
    step();
    drain();
    idle(2);
    chk("rand_done", 32'(done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
